// File: rtl/fast_comparator.sv
// Registered unsigned magnitude comparator (above = A>B, below = A<B) built as a log2-depth merge tree.
// Defining FAST_COMPARATOR_PIPE_EN inserts a mid-tree register stage (latency 2 instead of 1).
module fast_comparator #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WORD_WIDTH-1:0] a_i,
  input  logic [WORD_WIDTH-1:0] b_i,
  input  logic                  valid_i,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  valid_o
);

  // Handshake: valid_i qualifies a_i/b_i in the cycle it is high; there is no ready, so a pair is
  // taken every clock. valid_o is valid_i delayed by the fixed latency and qualifies above_o/below_o.

  localparam int LEVELS   = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 0;
  localparam int PW       = 1 << LEVELS;
  localparam int PIPE_LVL = (LEVELS + 1) / 2;

  logic [PW-1:0] a_pad;
  logic [PW-1:0] b_pad;

  // Zero padding above the MSB: equal zero bits produce gt=lt=0 leaves, which never win a merge.
  assign a_pad = PW'(a_i);
  assign b_pad = PW'(b_i);

  for (genvar l = 0; l <= LEVELS; l++) begin : lvl
    localparam int N = PW >> l;
    logic [N-1:0] gt_c;
    logic [N-1:0] lt_c;
    logic [N-1:0] gt_s;
    logic [N-1:0] lt_s;

    if (l == 0) begin : g_leaf
      assign gt_c = a_pad & ~b_pad;
      assign lt_c = ~a_pad & b_pad;
    end else begin : g_merge
      for (genvar i = 0; i < N; i++) begin : node
        assign gt_c[i] = lvl[l-1].gt_s[2*i+1] | (~lvl[l-1].lt_s[2*i+1] & lvl[l-1].gt_s[2*i]);
        assign lt_c[i] = lvl[l-1].lt_s[2*i+1] | (~lvl[l-1].gt_s[2*i+1] & lvl[l-1].lt_s[2*i]);
      end
    end

`ifdef FAST_COMPARATOR_PIPE_EN
    if (l == PIPE_LVL) begin : g_reg
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          gt_s <= '0;
          lt_s <= '0;
        end else begin
          gt_s <= gt_c;
          lt_s <= lt_c;
        end
      end
    end else begin : g_thru
      assign gt_s = gt_c;
      assign lt_s = lt_c;
    end
`else
    assign gt_s = gt_c;
    assign lt_s = lt_c;
`endif
  end

  logic valid_s;

`ifdef FAST_COMPARATOR_PIPE_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_s <= 1'b0;
    end else begin
      valid_s <= valid_i;
    end
  end
`else
  assign valid_s = valid_i;
`endif

  // Results register every cycle whether or not the pair is qualified.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      above_o <= 1'b0;
      below_o <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      above_o <= lvl[LEVELS].gt_s[0];
      below_o <= lvl[LEVELS].lt_s[0];
      valid_o <= valid_s;
    end
  end

endmodule

// File: tb/tb_fast_comparator.sv
// Self-checking bench for fast_comparator at WORD_WIDTH 8, 5, 4 and 1, in either build configuration.
module tb_fast_comparator;

`ifdef FAST_COMPARATOR_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [4:0] a5 = '0, b5 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic       above8, below8, valid8;
  logic       above5, below5, valid5;
  logic       above4, below4, valid4;
  logic       above1, below1, valid1;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-cycle expectation: {v8,above8,below8, v5,.., v4,.., v1,..}
  logic [11:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [4:0] a5;
    logic [4:0] b5;
    logic       v;
    logic [1:0] x8;
    logic [1:0] x5;
  } vec_t;

  fast_comparator #(.WORD_WIDTH(8)) u_w8 (.clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8),
    .valid_i(valid), .above_o(above8), .below_o(below8), .valid_o(valid8));
  fast_comparator #(.WORD_WIDTH(5)) u_w5 (.clk_i(clk), .rst_i(rst), .a_i(a5), .b_i(b5),
    .valid_i(valid), .above_o(above5), .below_o(below5), .valid_o(valid5));
  fast_comparator #(.WORD_WIDTH(4)) u_w4 (.clk_i(clk), .rst_i(rst), .a_i(a4), .b_i(b4),
    .valid_i(valid), .above_o(above4), .below_o(below4), .valid_o(valid4));
  fast_comparator #(.WORD_WIDTH(1)) u_w1 (.clk_i(clk), .rst_i(rst), .a_i(a1), .b_i(b1),
    .valid_i(valid), .above_o(above1), .below_o(below1), .valid_o(valid1));

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [1:0] cmp(input logic [7:0] a, input logic [7:0] b);
    return {a > b, a < b};
  endfunction

  function automatic void check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endfunction

  function automatic void check_all(input logic [11:0] e);
    check("w8_valid", valid8, e[11]);
    check("w8_above", above8, e[10]);
    check("w8_below", below8, e[9]);
    check("w5_valid", valid5, e[8]);
    check("w5_above", above5, e[7]);
    check("w5_below", below5, e[6]);
    check("w4_valid", valid4, e[5]);
    check("w4_above", above4, e[4]);
    check("w4_below", below4, e[3]);
    check("w1_valid", valid1, e[2]);
    check("w1_above", above1, e[1]);
    check("w1_below", below1, e[0]);
  endfunction

  // Driver: apply one pair to every DUT at the falling edge and record what must emerge.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [4:0] ra5,
                       input logic [4:0] rb5, input logic v, input logic [1:0] x8,
                       input logic [1:0] x5);
    @(negedge clk);
    a8 = a;  b8 = b;  a5 = ra5;  b5 = rb5;
    a4 = a[3:0];  b4 = b[3:0];  a1 = a[0];  b1 = b[0];
    valid = v;
    if (!rst)
      exp_q.push_back({v, x8, v, x5, v, cmp({4'h0, a[3:0]}, {4'h0, b[3:0]}),
                       v, cmp({7'h0, a[0]}, {7'h0, b[0]})});
  endtask

  // Scoreboard: after each rising edge, the entry pushed LAT edges ago must be on the outputs;
  // with nothing that old in flight (start-up, post-reset) every output must be 0.
  always @(posedge clk) begin
    logic [11:0] e;
    #1;
    if (rst) exp_q.delete();
    if (exp_q.size() >= LAT) e = exp_q.pop_front();
    else e = '0;
    check_all(e);
  end

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'd200, 8'd13,  5'd31, 5'd30, 1'b1, 2'b10, 2'b10};
    vecs[1] = '{8'h7F,  8'h80,  5'd1,  5'd16, 1'b1, 2'b01, 2'b01};
    vecs[2] = '{8'hA5,  8'hA5,  5'd0,  5'd0,  1'b1, 2'b00, 2'b00};
    vecs[3] = '{8'h00,  8'h00,  5'd31, 5'd31, 1'b0, 2'b00, 2'b00};
    vecs[4] = '{8'hFF,  8'h00,  5'd16, 5'd15, 1'b1, 2'b10, 2'b10};
    vecs[5] = '{8'h00,  8'hFF,  5'd0,  5'd31, 1'b0, 2'b01, 2'b01};
    vecs[6] = '{8'h01,  8'h00,  5'd15, 5'd16, 1'b1, 2'b10, 2'b01};
    vecs[7] = '{8'h80,  8'h7F,  5'd30, 5'd31, 1'b1, 2'b10, 2'b01};

    // Reset state
    repeat (2) @(negedge clk);
    check_all('0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++)
      drive(vecs[i].a, vecs[i].b, vecs[i].a5, vecs[i].b5, vecs[i].v, vecs[i].x8, vecs[i].x5);

    // Mid-cycle reset with results in flight
    drive(8'd200, 8'd13, 5'd31, 5'd30, 1'b1, 2'b10, 2'b10);
    drive(8'd250, 8'd249, 5'd17, 5'd3, 1'b1, 2'b10, 2'b10);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all('0);
    exp_q.delete();
    drive(8'h00, 8'h00, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00);
    drive(8'h00, 8'h00, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    drive(8'd9, 8'd3, 5'd2, 5'd7, 1'b0, 2'b10, 2'b01);
    drive(8'd200, 8'd13, 5'd1, 5'd16, 1'b1, 2'b10, 2'b01);

    // Exhaustive 4-bit sweep (low nibble of the 8-bit operands), random upper bits and valid
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ra, rb;
      logic [4:0] r5a, r5b;
      logic [3:0] ua, ub;
      ua  = 4'($urandom_range(0, 15));
      ub  = 4'($urandom_range(0, 15));
      ra  = {ua, 4'(i >> 4)};
      rb  = {ub, 4'(i)};
      r5a = 5'($urandom_range(0, 31));
      r5b = 5'($urandom_range(0, 31));
      drive(ra, rb, r5a, r5b, 1'($urandom_range(0, 1)), cmp(ra, rb),
            cmp({3'b000, r5a}, {3'b000, r5b}));
    end

    // Drain
    repeat (LAT + 1) drive(8'h00, 8'h00, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00);
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fast_comparator.md
FAST_COMPARATOR -- requirements
Module: fast_comparator

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 8, giving the operand width in bits; legal range is 1 or more.
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit, an asynchronous active-high reset.
REQ-004 The block SHALL have port a_i, input, WORD_WIDTH bits, operand A (unsigned).
REQ-005 The block SHALL have port b_i, input, WORD_WIDTH bits, operand B (unsigned).
REQ-006 The block SHALL have port valid_i, input, 1 bit, qualifying a_i/b_i in the current cycle.
REQ-007 The block SHALL have port above_o, output, 1 bit, high when A > B.
REQ-008 The block SHALL have port below_o, output, 1 bit, high when A < B.
REQ-009 The block SHALL have port valid_o, output, 1 bit, qualifying above_o/below_o.

Function
REQ-010 The block SHALL compute above = (A > B) and below = (A < B) as unsigned comparisons over the full WORD_WIDTH bits.
REQ-011 For A == B, both above_o and below_o SHALL be 0, and above_o and below_o SHALL never be 1 together.
REQ-012 The compare logic SHALL be a log2-depth tree: leaf per bit gt = a & ~b, lt = ~a & b; merge (hi, lo) gives gt = gt_hi | (~lt_hi & gt_lo) and lt = lt_hi | (~gt_hi & lt_lo).
REQ-013 Non-power-of-two WORD_WIDTH SHALL be handled by padding both operands with zeros above the MSB up to the next power of two, with no effect on the result.
REQ-014 WORD_WIDTH = 1 SHALL reduce to the single leaf, with no merge stages.
REQ-015 Without the pipeline option, above_o, below_o and valid_o SHALL be registered with a latency of exactly 1 clock from a_i/b_i/valid_i.
REQ-016 Registered results SHALL update every cycle regardless of valid_i; valid_o SHALL be valid_i delayed by the same latency.
REQ-017 There SHALL be no backpressure: a new operand pair SHALL be accepted every cycle, giving a throughput of 1 per clock.

Reset
REQ-018 While rst_i = 1, above_o, below_o, valid_o and every internal pipeline register SHALL be 0 immediately, independent of clk_i.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight results; the first valid_o after reset release SHALL correspond to the first valid_i sampled after release.

Configuration
REQ-020 When macro FAST_COMPARATOR_PIPE_EN is defined, a register stage SHALL be inserted after merge level ceil(log2(padded width)/2), making total latency 2 clocks for all outputs including valid_o.
REQ-021 When FAST_COMPARATOR_PIPE_EN is not defined, latency SHALL be 1 clock, with no intermediate register.
REQ-022 Function and reset values SHALL be identical in both configurations apart from latency.

Verification
REQ-023 The bench SHALL cover WORD_WIDTH = 8, A = 200, B = 13, valid_i = 1 -> after latency: above_o = 1, below_o = 0, valid_o = 1.
REQ-024 The bench SHALL cover WORD_WIDTH = 8, A = 0x7F, B = 0x80 -> above_o = 0, below_o = 1 (unsigned, MSB decides).
REQ-025 The bench SHALL cover A = B = 0xA5, and A = B = 0 -> above_o = 0, below_o = 0.
REQ-026 The bench SHALL cover WORD_WIDTH = 5 (padding), A = 31, B = 30 -> above_o = 1; and A = 1, B = 16 -> below_o = 1.
REQ-027 The bench SHALL cover rst_i asserted between clock edges with valid data in flight -> all outputs 0 at once, and valid_o = 0 until new valid_i passes the latency.
REQ-028 The bench SHALL run an exhaustive sweep for WORD_WIDTH = 4 (all 256 pairs) in both configurations -> every result matches A > B and A < B, with valid_o aligned to the latency.
